// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for the Avalon-MM clock divider controller.
//   - register address map and CTRL/STATUS bit positions
//   - FSM state type (encoding is visible in STATUS[3:2])
//   - smallest legal divisor
package clk_div_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_TICKS  = 2'd3;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_SRST_BIT  = 1;

    localparam int unsigned STAT_RUN_BIT   = 0;
    localparam int unsigned STAT_PEND_BIT  = 1;
    localparam int unsigned STAT_STATE_LSB = 2;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, active divisor and divided-clock generation.
//   i_clk/i_rst : clock, asynchronous active-high reset
//   i_run       : controller is in RUN or STOP (counter advances)
//   i_clr       : force counter to 0 (controller re-entering HOLD)
//   i_load      : load active divisor from i_div
//   i_div       : divisor value to load (also used on every counter wrap)
//   o_div       : active divisor
//   o_last      : counter is at N-1 (combinational)
//   o_clk       : divided clock, registered
//   o_tick      : one-cycle strobe per divided period, registered
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2500
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    output logic [DIV_W-1:0] o_div,
    output logic             o_last,
    output logic             o_clk,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_clk;
    logic             r_tick;
    logic             w_last;

    assign w_last = (r_cnt == (r_div - DIV_W'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_div  <= DIV_W'(DEFAULT_DIV);
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            if (!i_run || i_clr || w_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + DIV_W'(1);

            // A wrap starts a new period, so the divisor may change only here
            // (or on an explicit load), never inside a running period.
            if (i_load || (i_run && w_last))
                r_div <= i_div;

            r_clk  <= i_run && (r_cnt < (r_div >> 1));
            r_tick <= i_run && w_last;
        end
    end

    assign o_div  = r_div;
    assign o_last = w_last;
    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: Avalon-MM controller for the programmable clock divider.
//   clk, clk_rst       : clock, asynchronous active-high reset
//   avs_*              : Avalon-MM slave (no waitrequest, read latency 1)
//                        0 CTRL, 1 DIV, 2 STATUS, 3 TICKS
//   clk_out            : divided clock, registered
//   clk_rst_out        : reset for the divided-clock domain, registered
//   tick               : one-cycle strobe per divided period, registered
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2500,
    parameter int unsigned RST_HOLD    = 4
) (
    input  logic        clk,
    input  logic        clk_rst,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        clk_out,
    output logic        clk_rst_out,
    output logic        tick
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_en;
    logic              r_soft;
    logic [HOLD_W-1:0] r_hold;
    logic [DIV_W-1:0]  r_shadow;
    logic [31:0]       r_ticks;
    logic              r_rst_out;

    logic              w_ctrl_wr;
    logic              w_div_wr;
    logic              w_ticks_wr;
    logic              w_idle_div_wr;
    logic [DIV_W-1:0]  w_div_clamped;
    logic [DIV_W-1:0]  w_load_val;
    logic [DIV_W-1:0]  w_active;
    logic              w_running;
    logic              w_enter_hold;
    logic              w_load;
    logic              w_last;
    logic              w_core_clk;
    logic              w_core_tick;
    logic [31:0]       w_rd_mux;
    logic              w_unused;

    assign w_unused = ^avs_writedata[31:DIV_W];

    assign w_ctrl_wr     = avs_write && (avs_address == ADDR_CTRL);
    assign w_div_wr      = avs_write && (avs_address == ADDR_DIV);
    assign w_ticks_wr    = avs_write && (avs_address == ADDR_TICKS);
    assign w_div_clamped = (avs_writedata[DIV_W-1:0] < DIV_W'(MIN_DIV)) ?
                           DIV_W'(MIN_DIV) : avs_writedata[DIV_W-1:0];

    assign w_running     = (r_state == ST_RUN) || (r_state == ST_STOP);
    assign w_idle_div_wr = w_div_wr && (r_state == ST_IDLE);

    // FSM acts on the registered EN / soft-reset request, one cycle after
    // the bus write.
    always_comb begin
        w_state_next = r_state;
        if (r_soft) begin
            w_state_next = ST_HOLD;
        end else begin
            case (r_state)
                ST_IDLE: if (r_en) w_state_next = ST_HOLD;
                ST_HOLD: if (r_hold == HOLD_W'(RST_HOLD - 1)) w_state_next = ST_RUN;
                ST_RUN:  if (!r_en) w_state_next = ST_STOP;
                ST_STOP: begin
                    if (r_en)
                        w_state_next = ST_RUN;
                    else if (w_last)
                        w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_enter_hold = (w_state_next == ST_HOLD) && ((r_state != ST_HOLD) || r_soft);
    assign w_load       = w_enter_hold || w_idle_div_wr;
    // In IDLE a DIV write goes straight through; otherwise the shadow is used.
    assign w_load_val   = w_idle_div_wr ? w_div_clamped : r_shadow;

    clk_div_core #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .i_clk  (clk),
        .i_rst  (clk_rst),
        .i_run  (w_running),
        .i_clr  (w_enter_hold),
        .i_load (w_load),
        .i_div  (w_load_val),
        .o_div  (w_active),
        .o_last (w_last),
        .o_clk  (w_core_clk),
        .o_tick (w_core_tick)
    );

    always_ff @(posedge clk or posedge clk_rst) begin
        if (clk_rst) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_soft    <= 1'b0;
            r_hold    <= '0;
            r_shadow  <= DIV_W'(DEFAULT_DIV);
            r_ticks   <= '0;
            r_rst_out <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_hold    <= ((r_state == ST_HOLD) && !r_soft) ? r_hold + HOLD_W'(1) : '0;
            r_rst_out <= !w_running;

            r_soft <= w_ctrl_wr && avs_writedata[CTRL_EN_BIT] && avs_writedata[CTRL_SRST_BIT];
            if (w_ctrl_wr)
                r_en <= avs_writedata[CTRL_EN_BIT];

            if (w_div_wr)
                r_shadow <= w_div_clamped;

            // A clearing write beats a simultaneous tick.
            if (w_ticks_wr)
                r_ticks <= '0;
            else if (w_core_tick)
                r_ticks <= r_ticks + 32'd1;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            ADDR_CTRL:   w_rd_mux[CTRL_EN_BIT] = r_en;
            ADDR_DIV:    w_rd_mux[DIV_W-1:0]   = r_shadow;
            ADDR_STATUS: begin
                w_rd_mux[STAT_RUN_BIT]         = (r_state == ST_RUN);
                w_rd_mux[STAT_PEND_BIT]        = (r_shadow != w_active);
                w_rd_mux[STAT_STATE_LSB +: 2]  = r_state;
            end
            ADDR_TICKS:  w_rd_mux = r_ticks;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge clk_rst) begin
        if (clk_rst) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            avs_readdata      <= avs_read ? w_rd_mux : '0;
        end
    end

    assign clk_out     = w_core_clk;
    assign tick        = w_core_tick;
    assign clk_rst_out = r_rst_out;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

    localparam int DIV_W = 16;
    localparam int DEF   = 2500;
    localparam int RH    = 4;

    logic        clk = 1'b0;
    logic        clk_rst = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        clk_out;
    logic        clk_rst_out;
    logic        tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF),
        .RST_HOLD    (RH)
    ) dut (
        .clk               (clk),
        .clk_rst           (clk_rst),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .clk_out           (clk_out),
        .clk_rst_out       (clk_rst_out),
        .tick              (tick)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 hold, 2 run, 3 stop
    int          m_mode, m_hold_left, m_cnt, m_act, m_shadow;
    bit          m_en, m_soft;
    logic [31:0] m_ticks;
    bit          m_clk, m_tick, m_rst;
    bit          m_rdv;
    logic [31:0] m_rdd;

    function automatic logic [31:0] m_reg(input int a);
        case (a)
            0: return {31'd0, m_en};
            1: return m_shadow;
            2: return (m_mode << 2) | ((m_shadow != m_act) << 1) | (m_mode == 2);
            default: return m_ticks;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hold_left = 0; m_cnt = 0; m_act = DEF; m_shadow = DEF;
        m_en = 0; m_soft = 0; m_ticks = 0;
        m_clk = 0; m_tick = 0; m_rst = 1; m_rdv = 0; m_rdd = 0;
    endtask

    task automatic model_step();
        bit running, wrap, div_wr, enter_hold, n_en, n_soft;
        int n_mode, n_hold, n_cnt, n_act, n_shadow, dv;
        logic [31:0] n_ticks, n_rdd;
        running = (m_mode == 2) || (m_mode == 3);
        wrap    = running && (m_cnt == m_act - 1);
        n_rdd   = avs_read ? m_reg(avs_address) : 32'd0;
        div_wr  = avs_write && (avs_address == 1);
        dv      = avs_writedata[15:0];
        if (dv < 2) dv = 2;
        n_en = m_en; n_soft = 0;
        if (avs_write && avs_address == 0) begin
            n_en   = avs_writedata[0];
            n_soft = avs_writedata[0] && avs_writedata[1];
        end
        n_mode = m_mode; n_hold = m_hold_left;
        if (m_soft) begin
            n_mode = 1; n_hold = RH;
        end else if (m_mode == 0) begin
            if (m_en) begin n_mode = 1; n_hold = RH; end
        end else if (m_mode == 1) begin
            if (m_hold_left == 1) n_mode = 2; else n_hold = m_hold_left - 1;
        end else if (m_mode == 2) begin
            if (!m_en) n_mode = 3;
        end else begin
            if (m_en) n_mode = 2; else if (wrap) n_mode = 0;
        end
        enter_hold = (n_mode == 1) && ((m_mode != 1) || m_soft);
        n_cnt = (running && (n_mode == 2 || n_mode == 3)) ? (m_cnt + 1) % m_act : 0;
        n_act = m_act;
        if (wrap || enter_hold) n_act = m_shadow;
        if (m_mode == 0 && div_wr) n_act = dv;
        n_shadow = div_wr ? dv : m_shadow;
        n_ticks  = (avs_write && avs_address == 3) ? 32'd0 : m_ticks + (m_tick ? 32'd1 : 32'd0);
        // registered outputs from the pre-edge situation
        m_clk  = running && (m_cnt < m_act / 2);
        m_tick = wrap;
        m_rst  = !running;
        m_rdv  = avs_read;
        m_rdd  = n_rdd;
        m_mode = n_mode; m_hold_left = n_hold; m_cnt = n_cnt; m_act = n_act;
        m_shadow = n_shadow; m_ticks = n_ticks; m_en = n_en; m_soft = n_soft;
    endtask

    always @(posedge clk or posedge clk_rst) begin
        if (clk_rst) model_reset();
        else         model_step();
    end

    always @(negedge clk) begin
        if (!clk_rst) begin
            check("clk_out", clk_out, m_clk);
            check("tick", tick, m_tick);
            check("clk_rst_out", clk_rst_out, m_rst);
            check("readdatavalid", avs_readdatavalid, m_rdv);
            if (m_rdv) check("readdata", avs_readdata, m_rdd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        step(1);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        step(1);
        avs_read = 1'b0;
        check("read_latency", avs_readdatavalid, 1);
        d = avs_readdata;
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (tick !== 1'b1 && cyc < 200);
        check("tick_within_bound", tick, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int c, fall, highs, first, a, b;
        bit done;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_rst_out", clk_rst_out, 1);
        check("rst_clk_out", clk_out, 0);
        check("rst_rvalid", avs_readdatavalid, 0);
        check("rst_rdata", avs_readdata, 0);
        @(negedge clk);
        clk_rst = 1'b0;
        step(1);
        rd(1, d); check("rst_div", d, 2500);
        rd(3, d); check("rst_ticks", d, 0);
        rd(0, d); check("rst_ctrl", d, 0);
        rd(2, d); check("rst_status", d, 0);

        // start with N=4
        wr(1, 4);
        wr(0, 1);
        fall = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (!clk_rst_out) begin fall = k; break; end
        end
        check("rst_fall_cycle", fall, 6);
        check("pat0", clk_out, 1);
        step(1); check("pat1", clk_out, 1);
        step(1); check("pat2", clk_out, 0);
        step(1); check("pat3", clk_out, 0);
        check("first_tick", tick, 1);
        step(400);
        rd(3, d);
        checks++;
        if (d < 99 || d > 102) begin
            errors++;
            $display("FAIL ticks_range: got %0d expected 99..102", d);
        end

        // divisor change mid-period
        wait_tick(c);
        wr(1, 6);
        rd(2, d); check("pending_set", (d >> 1) & 1, 1);
        wait_tick(c); check("old_period_kept", c, 2);
        wait_tick(c); check("new_period", c, 6);
        rd(2, d); check("pending_clear", (d >> 1) & 1, 0);

        // clamp and odd divisor
        wr(1, 0);
        rd(1, d); check("clamp_div", d, 2);
        wait_tick(c); wait_tick(c); wait_tick(c);
        check("period_2", c, 2);
        step(1); a = clk_out;
        step(1); b = clk_out;
        check("toggle", a ^ b, 1);
        wr(1, 5);
        wait_tick(c); wait_tick(c);
        highs = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (clk_out) highs++;
        end
        check("odd_high_cycles", highs, 2);
        check("odd_period_tick", tick, 1);

        // stop at cnt=1 with N=4
        wr(1, 4);
        wait_tick(c); wait_tick(c);
        step(1);
        wr(0, 0);
        check("stop_t0_rst", clk_rst_out, 0);
        step(1); check("stop_t1_rst", clk_rst_out, 0);
        step(1); check("stop_t2_rst", clk_rst_out, 0);
        check("stop_t2_tick", tick, 1);
        step(1); check("stop_t3_rst", clk_rst_out, 1);
        rd(2, d); check("stop_status", d, 0);

        // soft reset in RUN
        wr(0, 1);
        step(20);
        wr(0, 3);
        highs = 0; first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (clk_rst_out) begin
                highs++;
                if (first == 0) first = k;
            end
        end
        check("soft_hold_len", highs, 4);
        check("soft_hold_start", first, 2);

        // TICKS clear collides with a tick
        wait_tick(c);
        wr(3, 32'h1234);
        rd(3, d); check("ticks_clear_wins", d, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            avs_address = 2'($urandom_range(0, 3));
            avs_write   = ($urandom_range(0, 99) < 15);
            avs_read    = ($urandom_range(0, 3) == 0);
            case (avs_address)
                2'd0: avs_writedata = ($urandom & 32'hFFFF_FFFC) |
                                      (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0) |
                                      (($urandom_range(0, 9) != 0) ? 32'd1 : 32'd0);
                2'd1: avs_writedata = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 9);
                default: avs_writedata = $urandom;
            endcase
            step(1);
            avs_write = 1'b0;
            avs_read  = 1'b0;
        end

        // asynchronous reset while running
        wr(1, 8);
        wr(0, 1);
        step(30);
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (clk_out) done = 1;
            else step(1);
        end
        check("clk_high_before_rst", clk_out, 1);
        #3;
        clk_rst = 1'b1;
        #1;
        check("async_clk_out", clk_out, 0);
        check("async_tick", tick, 0);
        check("async_clk_rst_out", clk_rst_out, 1);
        check("async_rvalid", avs_readdatavalid, 0);
        repeat (2) @(negedge clk);
        clk_rst = 1'b0;
        step(1);
        rd(1, d); check("post_rst_div", d, 2500);
        rd(0, d); check("post_rst_ctrl", d, 0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Avalon-MM-configurable controller for the programmable clock divider. It owns the divisor, sequences divider start, stop and reset, and produces a divided clock (`clk_out`) with its companion reset (`clk_rst_out`) and a one-cycle `tick` strobe for downstream logic. It sits on the FPGA's Avalon-MM bus next to the LPC master, so software can retune or restart the divided clock without glitches.

## Interface
- `DIV_W`, 16: divisor width in bits.
- `DEFAULT_DIV`, 2500: divisor loaded at reset.
- `RST_HOLD`, 4: number of cycles `clk_rst_out` stays high on every start or soft reset.
- `clk` in 1: sole clock.
- `clk_rst` in 1: reset, asynchronous, active-high.
- `avs_address` in 2: register select.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_read` in 1: read strobe.
- `avs_readdata` out 32: read data.
- `avs_readdatavalid` out 1: read data valid.
- `clk_out` out 1: divided clock, registered.
- `clk_rst_out` out 1: reset for the divided-clock domain, registered.
- `tick` out 1: one-cycle pulse per divided period, registered.

## Operation
- Registers:
  - **0 CTRL**: bit0 EN (R/W). bit1 SOFT_RST (write-1 pulse, reads 0).
  - **1 DIV**: shadow divisor N, in bits [DIV_W-1:0]. A write of 0 or 1 stores 2.
  - **2 STATUS** (RO): bit0 running (state RUN), bit1 div_pending (shadow ≠ active), bits[3:2] state encoding.
  - **3 TICKS**: 32-bit count of `tick` pulses, wraps at 2^32. Any write clears it to 0.
- Unused address bits and unused register bits read 0.
- FSM states: IDLE, HOLD, RUN, STOP.
  - IDLE → HOLD when EN is written 1.
  - HOLD → RUN after `RST_HOLD` cycles in HOLD.
  - RUN → STOP when EN is written 0.
  - STOP → IDLE when the period counter reaches N-1.
  - SOFT_RST written with EN=1 (already set, or set in the same write) → HOLD from any state; the hold counter restarts.
  - SOFT_RST written with EN=0 is ignored.
- Period counter `cnt` counts 0..N-1 in RUN and STOP, then wraps to 0. It is held at 0 in IDLE and HOLD.
- Active divisor:
  - Copied from the shadow on entry to HOLD and on every cnt wrap.
  - In IDLE, every DIV write also updates the active divisor.
  - A DIV write never changes a period already in progress.
- Output registers (set from the current state and cnt):
  - `clk_out` is 1 iff state ∈ {RUN, STOP} and cnt < N>>1. For odd N the low phase is one cycle longer.
  - `tick` is 1 iff state ∈ {RUN, STOP} and cnt == N-1.
  - `clk_rst_out` is 1 iff state ∈ {IDLE, HOLD}.
- TICKS increments on each `tick` pulse. A TICKS write in the same cycle as a tick wins: result is 0.
- A single CTRL write of EN=0 with SOFT_RST=1 is treated as EN=0: RUN → STOP.
- EN written 1 while in STOP: return to RUN, cnt continues without reset.

## Timing
- Values held during `clk_rst`:
  - State IDLE, EN=0, DIV shadow and active = `DEFAULT_DIV`, TICKS=0.
  - `clk_out`=0, `tick`=0, `clk_rst_out`=1, `avs_readdata`=0, `avs_readdatavalid`=0.
- `clk_rst` asserted mid-operation forces all of the above immediately, without waiting for a clock edge.
- Bus timing:
  - No waitrequest; a write takes effect at the edge where `avs_write`=1.
  - Read latency is 1: `avs_readdatavalid` is high exactly one cycle after `avs_read`, with the register value as sampled at the `avs_read` edge.
  - Simultaneous read and write to the same register returns the old value.
- Start sequence, with the CTRL write (EN=1) at edge t:
  - HOLD during t+1..t+RST_HOLD; RUN from t+RST_HOLD+1.
  - `clk_rst_out` falls 1 cycle after RUN entry; `clk_out` first rises on that same edge.
- Divided-clock outputs lag cnt by 1 cycle.
- Stop: `clk_out` completes its current period, then stays low; `clk_rst_out` rises 1 cycle after IDLE entry.

## Structure
- Package `clk_div_pkg`:
  - Register address constants and CTRL/STATUS bit indices.
  - FSM state enum (2 bits).
  - `MIN_DIV` = 2.
- Sub-module `clk_div_core`:
  - Contains the period counter, active-divisor register, `clk_out`/`tick` generation, with a load strobe and a run input.
  - `clk_div_ctrl` holds the bus interface, registers, FSM and TICKS.

## Test plan
- **Reset:** assert `clk_rst` for 3 cycles → `clk_rst_out`=1, `clk_out`=0, reading DIV returns 2500, reading TICKS returns 0.
- **Start:** write DIV=4, then CTRL=1 at edge t → `clk_rst_out` falls at t+6. `clk_out` repeats 1,1,0,0. `tick` fires every 4 cycles. After 12500 cycles, TICKS ≈ 3123 and matches the number of `tick` pulses seen by the bench.
- **Divisor change:** while running at DIV=4, write DIV=6 mid-period → the current period stays 4 cycles, the next is 6. STATUS.div_pending reads 1 in between, 0 after.
- **Clamp and odd divisor:** write DIV=0 → reads 2, `clk_out` toggles every cycle. Write DIV=5 → 2 cycles high, 3 low.
- **Stop and soft reset:**
  - EN=0 written at cnt=1 with N=4 → 2 more cycles of running, then IDLE, `clk_rst_out`=1.
  - SOFT_RST with EN=1 while in RUN → `clk_rst_out` high for 4 cycles, cnt restarts at 0.
- **Collisions:** a TICKS write in the same cycle as `tick` → reads 0. `clk_rst` asserted mid-RUN → outputs return to reset values within the same cycle.
